// File: rtl/rice_bit_packer.sv
// Packs right-aligned variable-length Rice codewords MSB-first into a continuous
// bitstream and emits it as WORD_W-bit words over a valid/ready handshake.
module rice_bit_packer #(
    parameter int WORD_W   = 16,
    parameter int MAX_CODE = 32,
    parameter int BUF_W    = 48
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iValid,
    input  logic [15:0]       iMSB,
    input  logic [15:0]       iLSB,
    input  logic [15:0]       iBitsUsed,
    output logic              oReady,
    input  logic              iFlush,
    output logic [WORD_W-1:0] oData,
    output logic              oValid,
    input  logic              iReady,
    output logic              oFlushDone,
    output logic [31:0]       oTotalBits,
    output logic              oError
);

    localparam int FW = $clog2(BUF_W + 1);
    localparam logic [FW-1:0] WORD_F = FW'(WORD_W);
    localparam logic [FW-1:0] ROOM_F = FW'(BUF_W - MAX_CODE);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t              state, state_n;
    logic [BUF_W-1:0]    acc, acc_s, acc_n, code_ext;
    logic [FW-1:0]       fill, fill_s, fill_n;
    logic [WORD_W-1:0]   data_n;
    logic [31:0]         total_n, code;
    logic [63:0]         mask;
    logic [7:0]          shamt;
    logic                slot_free, accept, bad, take, full_emit, pad_emit, emit;
    logic                valid_n, ready_n, done_n, err_n;

    always_comb begin
        slot_free = !oValid || iReady;
        accept    = iValid && oReady;
        bad       = iBitsUsed > 16'(MAX_CODE);
        take      = accept && !bad && (iBitsUsed != 16'd0);
        full_emit = (fill >= WORD_F) && slot_free;
        pad_emit  = (state == FLUSH) && (fill != '0) && (fill < WORD_F) && slot_free;
        emit      = full_emit || pad_emit;

        // Shift out the emitted word first, then append the new code behind what remains.
        acc_s  = emit ? (acc << WORD_W) : acc;
        fill_s = full_emit ? (fill - WORD_F) : (pad_emit ? '0 : fill);

        mask     = (64'd1 << iBitsUsed) - 64'd1;
        code     = {iMSB, iLSB} & mask[31:0];
        code_ext = BUF_W'(code);
        shamt    = 8'(BUF_W) - 8'(fill_s) - 8'(iBitsUsed);

        acc_n   = take ? (acc_s | (code_ext << shamt)) : acc_s;
        fill_n  = take ? (fill_s + FW'(iBitsUsed)) : fill_s;
        total_n = take ? (oTotalBits + {16'd0, iBitsUsed}) : oTotalBits;
        err_n   = oError || (accept && bad);

        data_n  = emit ? acc[BUF_W-1 -: WORD_W] : oData;
        valid_n = emit ? 1'b1 : (iReady ? 1'b0 : oValid);

        state_n = state;
        done_n  = 1'b0;
        case (state)
            RUN:   if (iFlush) state_n = FLUSH;
            FLUSH: if (fill == '0 || pad_emit) state_n = DRAIN;
            DRAIN: if (slot_free) begin
                state_n = RUN;
                done_n  = 1'b1;
            end
            default: state_n = RUN;
        endcase

        ready_n = (state_n == RUN) && (fill_n <= ROOM_F);
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state      <= RUN;
            acc        <= '0;
            fill       <= '0;
            oData      <= '0;
            oValid     <= 1'b0;
            oReady     <= 1'b0;
            oFlushDone <= 1'b0;
            oTotalBits <= '0;
            oError     <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            fill       <= fill_n;
            oData      <= data_n;
            oValid     <= valid_n;
            oReady     <= ready_n;
            oFlushDone <= done_n;
            oTotalBits <= total_n;
            oError     <= err_n;
        end
    end

endmodule
